// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised Mealy sequence detector.
// Optional programmable pattern: define SEQ_DET_PROG_PATTERN_EN.
package seq_det_pkg;

   localparam logic OVL_ON  = 1'b1;
   localparam logic OVL_OFF = 1'b0;

   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Increment that sticks at the all-ones value of a w-bit field.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] value,
      input int          width
   );
      logic [31:0] max_v;
      max_v = 32'hFFFF_FFFF >> (32 - width);
      return (value >= max_v) ? max_v : value + 32'd1;
   endfunction

endpackage

// File: rtl/seq_det_mealy_param_sat_counter.sv
// Saturating event counter with synchronous clear taking priority.
module sat_counter
   import seq_det_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (inc)
         q_d = W'(sat_inc(32'(q_q), W));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q_q <= '0;
      else
         q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/seq_det_mealy_param.sv
// Parametrised Mealy serial-pattern detector with match counter.
// Define SEQ_DET_PROG_PATTERN_EN for a run-time loadable pattern.
module seq_det_mealy_param
   import seq_det_pkg::*;
#(
   parameter int          LEN     = 4,
   parameter logic [31:0] PATTERN = 32'b1101,
   parameter int          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             en,
   input  logic             overlap,
   input  logic             cnt_clr,
`ifdef SEQ_DET_PROG_PATTERN_EN
   input  logic             pat_wr,
   input  logic [LEN-1:0]   pat_in,
`endif
   output logic             z,
   output logic             z_q,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int             FW       = clog2(LEN);
   localparam logic [FW-1:0]  FILL_MAX = FW'(LEN - 1);
   localparam logic [LEN-1:0] PAT_C    = PATTERN[LEN-1:0];

   if (LEN < 2 || LEN > 16 || (PATTERN >> LEN) != 0) begin : g_bad_cfg
      $error("seq_det_mealy_param: bad LEN/PATTERN");
   end

   logic [LEN-2:0] hist_q;
   logic [LEN-2:0] hist_d;
   logic [FW-1:0]  fill_q;
   logic [FW-1:0]  fill_d;
   logic [LEN-1:0] win;
   logic [LEN-1:0] pat_cur;
   logic           wr;
   logic           z_d;

`ifdef SEQ_DET_PROG_PATTERN_EN
   logic [LEN-1:0] pat_q;
   logic [LEN-1:0] pat_d;

   assign wr      = pat_wr;
   assign pat_cur = pat_q;
   assign pat_d   = pat_wr ? pat_in : pat_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pat_q <= PAT_C;
      else
         pat_q <= pat_d;
   end
`else
   assign wr      = 1'b0;
   assign pat_cur = PAT_C;
`endif

   assign win = {hist_q, x};

   always_comb begin
      z_d    = en & ~wr & (fill_q == FILL_MAX) & (win == pat_cur);
      hist_d = en ? win[LEN-2:0] : hist_q;
      fill_d = fill_q;
      if (wr)
         fill_d = '0;
      else if (en) begin
         // Non-overlap consumes the matched bits.
         if (z_d && overlap == OVL_OFF)
            fill_d = '0;
         else if (fill_q != FILL_MAX)
            fill_d = fill_q + FW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         z_q    <= z_d;
      end
   end

   assign z = z_d;

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (z_d),
      .q     (match_cnt)
   );

endmodule

// File: doc/seq_det_mealy_param.md
Name: seq_det_mealy_param

Overview:
Parametrised Mealy serial-pattern detector; successor to the fixed 1101 detector.
- Pattern length and value are set by parameters.
- Overlapping or non-overlapping matching is selected at run time.
- A sample-enable qualifies each input bit.
- Provides a registered copy of the match pulse and a saturating match counter.
- Sits in the serial front-end, between the bit-stream source and the framing/alarm logic.

Parameters:
LEN, 4, pattern length in bits (2..16).
PATTERN, 4'b1101, LEN-bit pattern; MSB is the earliest bit received.
CNT_W, 8, match counter width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
x  input  1  serial data bit
en  input  1  x is valid this cycle; when 0, no state change and z=0
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt
z  output  1  Mealy match, combinational from x/en/state
z_q  output  1  z registered (one-cycle delay, glitch-free)
match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Reset values: z_q=0, match_cnt=0. Internal history hist[LEN-2:0]=0. Internal fill counter fill=0. z=0 while reset is high.
- State: hist holds the last LEN-1 accepted bits. fill counts accepted bits since reset or since the last non-overlap match, saturating at LEN-1. fill is the FSM state.
- z = en & (fill==LEN-1) & ({hist,x}==PATTERN). Zero latency: z is valid in the same cycle as the final pattern bit.
- On a clock edge with en=1:
  - hist <= {hist[LEN-3:0],x}.
  - If z & ~overlap: fill <= 0, so the bits of the match are consumed.
  - Otherwise fill <= min(fill+1, LEN-1).
- On a clock edge with en=0: hist and fill hold; z_q <= 0.
- z_q <= z on every edge.
- match_cnt update:
  - cnt_clr has priority and forces match_cnt to 0, even if z=1 in the same cycle.
  - Else if z: increment, saturating at 2^CNT_W-1 (no wrap).
- Mode switch mid-stream: overlap is sampled every cycle. It affects only the fill update on the cycle a match occurs.
- Reset mid-sequence: the partial match is lost. No match is possible until LEN accepted bits after reset deassertion.
- Parameter checks: LEN<2 or PATTERN wider than LEN → elaboration error.

Optional Feature:
Macro SEQ_DET_PROG_PATTERN_EN.
- Defined:
  - Extra ports pat_wr (input, 1) and pat_in (input, LEN).
  - A pattern register, reset to PATTERN, is loaded with pat_in when pat_wr=1.
  - pat_wr also clears fill to 0 and suppresses z in that cycle.
  - The comparison uses the pattern register.
- Not defined: the pattern is the constant PATTERN, and the extra ports do not exist.

Decomposition:
- Package seq_det_pkg holds:
  - fill width function clog2(LEN);
  - mode encodings OVL_ON=1 / OVL_OFF=0;
  - a helper function sat_inc(value, width).
- One sub-module, sat_counter (params W; ports clk, reset, clr, inc, q), implements match_cnt.
- Detector core (history, fill, compare) stays in the top module.

Test Plan:
- Overlap=1, en=1, LEN=4, PATTERN=1101, x stream 0110110110011010 (first bit first) → z=1 on bit indices 4, 7, 14 only; z_q one cycle later; match_cnt=3.
- Same stream with overlap=0 → z=1 on indices 4 and 14 only (match at 7 suppressed because bit 4 was consumed); match_cnt=2.
- en deasserted for 3 cycles between bits 6 and 7 of the stream → z still at index 7; z=0 and z_q=0 while en=0.
- Reset asserted asynchronously after bits 1,1,0 of a match, then released and 1 applied → no z. Then 1101 applied → z on the 4th bit after release.
- CNT_W=2, 5 matches (input 1101 repeated, overlap=0) → match_cnt stops at 3. Then cnt_clr pulsed together with a match cycle → match_cnt=0.
- With SEQ_DET_PROG_PATTERN_EN defined: write pat_in=0110 → z=0 on the write cycle. Stream 0110 → z on the 4th bit; stream 1101 → no z.
